// File: rtl/fb_reader_pkg.sv
// Shared types and constants for the Wishbone framebuffer reader.
// Imported by the pixel FIFO and by the bus-master top level.
package fb_reader_pkg;

  typedef enum logic {IDLE, REQ} fb_state_t;

  typedef struct packed {
    logic        sof;
    logic [31:0] data;
  } fb_word_t;

  localparam logic [3:0] WB_SEL_ALL     = 4'hF;
  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

  // Index width that stays legal even for a single-entry range.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fb_fifo.sv
// First-word-fall-through FIFO of framebuffer words; head is visible
// combinationally whenever the FIFO is not empty, and reads as zero when empty.
module fb_fifo
  import fb_reader_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  fb_word_t                 wdata,
  output fb_word_t                 rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = idx_width(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fb_word_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push;
  logic            do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // A pop frees the slot in the same edge, so a full FIFO still takes a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/wshb_fb_reader.sv
// Wishbone classic read master that walks a linear 32-bit framebuffer and
// streams the words out through a FWFT pixel FIFO with valid/ready popping.
module wshb_fb_reader
  import fb_reader_pkg::*;
#(
  parameter int unsigned HDISP      = 800,
  parameter int unsigned VDISP      = 480,
  parameter logic [31:0] BASE_ADDR  = '0,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        enable,
  output logic [31:0] wb_adr,
  output logic        wb_stb,
  output logic        wb_cyc,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [2:0]  wb_cti,
  output logic [1:0]  wb_bte,
  input  logic [31:0] wb_dat_sm,
  input  logic        wb_ack,
  input  logic        wb_err,
  output logic [31:0] pix_data,
  output logic        pix_sof,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        frame_done,
  output logic        err_flag
);

  localparam int unsigned NPIX = HDISP * VDISP;
  localparam int unsigned PW   = idx_width(NPIX);
  localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned LW   = CW + 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(NPIX - 1);

  fb_state_t      state_q, state_d;
  logic [PW-1:0]  pix_idx_q, pix_idx_d;
  logic           err_q, err_d;
  logic           done_q, done_d;

  logic           term;
  logic           pop;
  logic           push;
  logic           room_after;
  logic [LW-1:0]  level_after;
  fb_word_t       fifo_wdata;
  fb_word_t       fifo_head;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;

  assign term = (state_q == REQ) && (wb_ack || wb_err);
  assign pop  = pix_valid && pix_ready;

  // Occupancy after this edge's push and pop, used to decide back-to-back issue.
  assign level_after = LW'(fifo_count) + LW'(1) - LW'(pop);
  assign room_after  = level_after < LW'(FIFO_DEPTH);

  always_comb begin
    state_d    = state_q;
    pix_idx_d  = pix_idx_q;
    err_d      = err_q;
    done_d     = 1'b0;
    push       = 1'b0;
    fifo_wdata = '0;
    case (state_q)
      IDLE: begin
        // Idling with enable low rewinds so the next frame starts at BASE_ADDR.
        if (!enable) begin
          pix_idx_d = '0;
        end else if (!fifo_full) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (term) begin
          push            = 1'b1;
          fifo_wdata.sof  = (pix_idx_q == '0);
          fifo_wdata.data = wb_err ? '0 : wb_dat_sm;
          if (wb_err) begin
            err_d = 1'b1;
          end
          if (pix_idx_q == LAST_IDX) begin
            pix_idx_d = '0;
            done_d    = 1'b1;
          end else begin
            pix_idx_d = pix_idx_q + PW'(1);
          end
          if (!(enable && room_after)) begin
            state_d = IDLE;
            if (!enable) begin
              pix_idx_d = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      pix_idx_q <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_idx_q <= pix_idx_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  fb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign wb_stb     = (state_q == REQ);
  assign wb_cyc     = wb_stb;
  assign wb_adr     = BASE_ADDR + 32'({pix_idx_q, 2'b00});
  assign wb_we      = 1'b0;
  assign wb_sel     = WB_SEL_ALL;
  assign wb_cti     = WB_CTI_CLASSIC;
  assign wb_bte     = WB_BTE_LINEAR;

  assign pix_valid  = !fifo_empty;
  assign pix_data   = fifo_head.data;
  assign pix_sof    = fifo_head.sof;
  assign frame_done = done_q;
  assign err_flag   = err_q;

endmodule

// File: tb/tb_wshb_fb_reader.sv
// Self-checking bench for wshb_fb_reader: a Wishbone slave model feeds a
// scoreboard of expected pixels, which the consumer side pops and compares.
module tb_wshb_fb_reader;

  localparam logic [31:0] BASE     = 32'h100;
  localparam int unsigned NPIX     = 8;
  localparam logic [31:0] LAST_ADR = BASE + 32'(4 * (NPIX - 1));

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        enable;
  logic [31:0] wb_adr;
  logic        wb_stb, wb_cyc, wb_we;
  logic [3:0]  wb_sel;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic [31:0] wb_dat_sm;
  logic        wb_ack, wb_err;
  logic [31:0] pix_data;
  logic        pix_sof, pix_valid, pix_ready, frame_done, err_flag;

  int total = 0;
  int bad   = 0;

  logic [32:0] sb_q[$];

  int          ack_cnt     = 0;
  int          ack_allow   = -1;
  int          fixed_delay = 1;
  bit          rand_delay  = 0;
  bit          rand_ready  = 0;
  bit          ready_ctl   = 1;
  bit          stray_req   = 0;
  logic [31:0] exp_adr     = BASE;
  logic [31:0] err_adr     = '1;
  logic [31:0] last_adr    = '0;
  int          adr_viol    = 0;
  int          max_q       = 0;
  int          frames_seen = 0;
  int          exp_frames  = 0;

  bit          s_busy;
  int          s_wait;
  logic [31:0] s_cap;
  int          a0;

  wshb_fb_reader #(
    .HDISP      (4),
    .VDISP      (2),
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (4)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .enable     (enable),
    .wb_adr     (wb_adr),
    .wb_stb     (wb_stb),
    .wb_cyc     (wb_cyc),
    .wb_we      (wb_we),
    .wb_sel     (wb_sel),
    .wb_cti     (wb_cti),
    .wb_bte     (wb_bte),
    .wb_dat_sm  (wb_dat_sm),
    .wb_ack     (wb_ack),
    .wb_err     (wb_err),
    .pix_data   (pix_data),
    .pix_sof    (pix_sof),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .frame_done (frame_done),
    .err_flag   (err_flag)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic wait_acks(input int target, input string tag);
    for (int i = 0; i < 5000 && ack_cnt < target; i++) begin
      @(posedge sys_clk);
      #1;
    end
    check(tag, 64'(ack_cnt >= target), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && wb_stb; i++) begin
      @(posedge sys_clk);
      #1;
    end
    check(tag, 64'(wb_stb), 64'd0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 500 && (sb_q.size() != 0 || pix_valid); i++) begin
      @(posedge sys_clk);
      #1;
    end
    check({tag, "_sb"}, 64'(sb_q.size()), 64'd0);
    check({tag, "_valid"}, 64'(pix_valid), 64'd0);
  endtask

  // Wishbone slave: memory words tagged with address and a running transfer count.
  initial begin : slave
    wb_ack    = 1'b0;
    wb_err    = 1'b0;
    wb_dat_sm = '0;
    s_busy    = 1'b0;
    s_wait    = 0;
    s_cap     = '0;
    forever begin
      @(posedge sys_clk);
      #1;
      wb_ack = 1'b0;
      wb_err = 1'b0;
      if (!wb_stb) begin
        s_busy = 1'b0;
        if (stray_req) begin
          wb_ack    = 1'b1;
          wb_dat_sm = 32'hDEAD_BEEF;
          stray_req = 1'b0;
        end
      end else begin
        if (!s_busy) begin
          s_busy = 1'b1;
          s_cap  = wb_adr;
          check("adr_seq", wb_adr, exp_adr);
          s_wait = rand_delay ? int'($urandom_range(0, 7)) : fixed_delay;
        end else if (wb_adr !== s_cap) begin
          adr_viol++;
        end
        if (s_wait > 0) begin
          s_wait--;
        end else if (ack_allow != 0) begin
          ack_cnt++;
          if (ack_allow > 0) ack_allow--;
          last_adr = wb_adr;
          if (wb_adr == err_adr) begin
            wb_err    = 1'b1;
            wb_dat_sm = 32'hFFFF_FFFF;
            err_adr   = '1;
            sb_q.push_back({(wb_adr == BASE), 32'h0});
          end else begin
            wb_ack    = 1'b1;
            wb_dat_sm = {wb_adr[15:0], ack_cnt[15:0]};
            sb_q.push_back({(wb_adr == BASE), wb_dat_sm});
          end
          if (wb_adr == LAST_ADR) begin
            exp_frames++;
            exp_adr = BASE;
          end else begin
            exp_adr = wb_adr + 32'd4;
          end
          s_busy = 1'b0;
        end
      end
    end
  end

  initial begin : ready_drv
    pix_ready = 1'b1;
    forever begin
      @(posedge sys_clk);
      #1;
      pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_ctl;
    end
  end

  // Consumer side: each pop must match the oldest outstanding expected word.
  initial begin : consumer
    logic [32:0] exp_w;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n) begin
        if (sb_q.size() > max_q) max_q = sb_q.size();
        if (frame_done) frames_seen++;
        if (pix_valid && pix_ready) begin
          if (sb_q.size() == 0) begin
            check("sb_underflow", 64'(pix_valid), 64'd0);
          end else begin
            exp_w = sb_q.pop_front();
            check("pix", 64'({pix_sof, pix_data}), 64'(exp_w));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    sys_rst_n = 1'b0;
    enable    = 1'b0;
    wait_cycles(3);
    check("rst_stb", 64'(wb_stb), 64'd0);
    check("rst_cyc", 64'(wb_cyc), 64'd0);
    check("rst_valid", 64'(pix_valid), 64'd0);
    check("rst_sof", 64'(pix_sof), 64'd0);
    check("rst_data", 64'(pix_data), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    check("rst_err", 64'(err_flag), 64'd0);
    check("const_we", 64'(wb_we), 64'd0);
    check("const_sel", 64'(wb_sel), 64'hF);
    check("const_cti", 64'(wb_cti), 64'd0);
    check("const_bte", 64'(wb_bte), 64'd0);
    sys_rst_n = 1'b1;
    wait_cycles(1);

    // Continuous streaming across frame wrap.
    enable = 1'b1;
    wait_acks(ack_cnt + 18, "t1_acks");
    check("t1_frames", 64'(frames_seen), 64'd2);
    enable = 1'b0;
    wait_idle("t1_idle");
    drain("t1_drain");
    exp_adr = BASE;

    // Stalled consumer: FIFO fills, then fetch resumes where it left off.
    ready_ctl = 1'b0;
    wait_cycles(2);
    a0     = ack_cnt;
    enable = 1'b1;
    wait_cycles(40);
    check("t2_acks", 64'(ack_cnt - a0), 64'd4);
    check("t2_stb_low", 64'(wb_stb), 64'd0);
    check("t2_valid", 64'(pix_valid), 64'd1);
    check("t2_last_adr", 64'(last_adr), 64'(BASE + 32'hC));
    ready_ctl = 1'b1;
    wait_acks(a0 + 8, "t2_resume");
    enable = 1'b0;
    wait_idle("t2_idle");
    drain("t2_drain");
    exp_adr = BASE;

    // Bus error on pixel 2.
    err_adr = BASE + 32'h8;
    a0      = ack_cnt;
    enable  = 1'b1;
    wait_acks(a0 + 5, "t3_acks");
    check("t3_err", 64'(err_flag), 64'd1);
    wait_cycles(10);
    check("t3_err_sticky", 64'(err_flag), 64'd1);
    enable = 1'b0;
    wait_idle("t3_idle");
    drain("t3_drain");
    exp_adr = BASE;

    // Enable drop while a transfer is outstanding.
    fixed_delay = 3;
    enable      = 1'b1;
    for (int i = 0; i < 200 && !(wb_stb && wb_adr == BASE + 32'h8); i++) wait_cycles(1);
    check("t4_reach108", 64'(wb_adr), 64'(BASE + 32'h8));
    enable = 1'b0;
    wait_cycles(1);
    check("t4_stb_held", 64'(wb_stb), 64'd1);
    check("t4_adr_held", 64'(wb_adr), 64'(BASE + 32'h8));
    wait_idle("t4_idle");
    wait_cycles(3);
    check("t4_stays_idle", 64'(wb_stb), 64'd0);
    check("t4_last_adr", 64'(last_adr), 64'(BASE + 32'h8));
    exp_adr = BASE;
    enable  = 1'b1;
    wait_acks(ack_cnt + 2, "t4_restart");
    enable = 1'b0;
    wait_idle("t4_idle2");
    drain("t4_drain");
    exp_adr     = BASE;
    fixed_delay = 1;

    // Reset mid-transfer with three words buffered, then a stray ack.
    ready_ctl = 1'b0;
    wait_cycles(2);
    ack_allow = 3;
    a0        = ack_cnt;
    enable    = 1'b1;
    for (int i = 0; i < 200 && (ack_cnt - a0) < 3; i++) wait_cycles(1);
    wait_cycles(3);
    check("t5_stalled_stb", 64'(wb_stb), 64'd1);
    check("t5_fifo_valid", 64'(pix_valid), 64'd1);
    check("t5_err_before", 64'(err_flag), 64'd1);
    sys_rst_n = 1'b0;
    enable    = 1'b0;
    wait_cycles(1);
    check("t5_rst_stb", 64'(wb_stb), 64'd0);
    check("t5_rst_valid", 64'(pix_valid), 64'd0);
    check("t5_rst_err", 64'(err_flag), 64'd0);
    check("t5_rst_data", 64'(pix_data), 64'd0);
    sb_q.delete();
    ack_allow = -1;
    exp_adr   = BASE;
    sys_rst_n = 1'b1;
    stray_req = 1'b1;
    wait_cycles(4);
    check("t5_stray_valid", 64'(pix_valid), 64'd0);
    check("t5_stray_stb", 64'(wb_stb), 64'd0);
    check("t5_stray_err", 64'(err_flag), 64'd0);

    // Random ack latency and random consumer backpressure.
    ready_ctl  = 1'b1;
    rand_delay = 1'b1;
    rand_ready = 1'b1;
    a0         = ack_cnt;
    enable     = 1'b1;
    wait_acks(a0 + 60, "t6_acks");
    enable     = 1'b0;
    rand_ready = 1'b0;
    wait_idle("t6_idle");
    drain("t6_drain");
    rand_delay = 1'b0;
    check("t6_adr_stable", 64'(adr_viol), 64'd0);
    check("t6_max_fill", 64'(max_q <= 4), 64'd1);
    check("t6_frames", 64'(frames_seen), 64'(exp_frames));
    check("t6_err_clear", 64'(err_flag), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
